// File: rtl/scale_pkg.sv
// Shared definitions for the 32<->16-bit scaling path (downscaler and unscaler).
package scale_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int unsigned STEP      = 2;
  localparam int unsigned MAX_STEPS = 8;

endpackage : scale_pkg

// File: rtl/shift_step_reg.sv
// Accumulator register: loads a zero-extended input word, shifts left by STEP, or holds.
module shift_step_reg #(
  parameter int unsigned DIN_W  = 16,
  parameter int unsigned DOUT_W = 32,
  parameter int unsigned STEP   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              shift_en_i,
  input  logic [DIN_W-1:0]  din_i,
  output logic [DOUT_W-1:0] q_o
);

  logic [DOUT_W-1:0] acc_q, acc_d;

  // Load has priority; the FSM never requests both in the same cycle.
  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = DOUT_W'(din_i);
    end else if (shift_en_i) begin
      acc_d = acc_q << STEP;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign q_o = acc_q;

endmodule : shift_step_reg

// File: rtl/unscale_16to32b.sv
// Restores a downscaled 16-bit word to 32 bits by shifting left STEP bits per cycle,
// with valid/ready handshakes on input and output.
module unscale_16to32b #(
  parameter int unsigned DIN_W  = 16,
  parameter int unsigned DOUT_W = 32,
  parameter int unsigned STEP   = 2,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DIN_W-1:0]  data_i,
  input  logic [CNT_W-1:0]  shift_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [DOUT_W-1:0] y_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              ovf_o
);

  import scale_pkg::state_e;
  import scale_pkg::IDLE;
  import scale_pkg::SHIFT;
  import scale_pkg::HOLD;

  localparam int unsigned      MAX_SHIFT = (DOUT_W - DIN_W) / STEP;
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_SHIFT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             load_c, shift_en_c;

  // Next state, counter and flag updates; ready/valid are registered from the next state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    load_c     = 1'b0;
    shift_en_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid_i && ready_q) begin
          load_c  = 1'b1;
          ovf_d   = (shift_i > MAX_CNT);
          cnt_d   = (shift_i > MAX_CNT) ? MAX_CNT : shift_i;
          state_d = (cnt_d == '0) ? HOLD : SHIFT;
        end
      end
      SHIFT: begin
        shift_en_c = 1'b1;
        cnt_d      = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  shift_step_reg #(
    .DIN_W (DIN_W),
    .DOUT_W(DOUT_W),
    .STEP  (STEP)
  ) u_acc (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (load_c),
    .shift_en_i(shift_en_c),
    .din_i     (data_i),
    .q_o       (y_o)
  );

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign ovf_o   = ovf_q;

endmodule : unscale_16to32b
